// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and the
// controller state type used by alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LS   = 4'b0011;
  localparam logic [3:0] OP_SRS  = 4'b0100;
  localparam logic [3:0] OP_URS  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_RRO  = 4'b1000;
  localparam logic [3:0] OP_LRO  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_SLTS = 4'b1011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier. One partial product is added per
// clock; the first one is taken on the start edge itself, so the full product
// is ready after WIDTH edges and done stays high until the next edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  // Load operands and add the first partial product on start, then step once per clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= {{WIDTH{1'b0}}, a & {WIDTH{b[0]}}};
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= {1'b0, b[WIDTH-1:1]};
      cnt    <= CW'(1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt == CW'(WIDTH)) begin
        busy <= 1'b0;
      end else begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
    end
  end

  assign done    = busy && (cnt == CW'(WIDTH));
  assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// Registered, valid/ready handshaked ALU. Single-cycle ops are computed
// combinationally and captured on the accepting edge; MUL hands off to the
// sequential multiplier and blocks new input until its result is loaded.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cr,
  output logic             ov,
  output logic             ng,
  output logic             zr,
  output logic             ill
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic               accept;
  logic               is_mul;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] rot_l;
  logic [2*WIDTH-1:0] rot_r;
  logic [WIDTH-1:0]   res;
  logic               res_cr;
  logic               res_ov;
  logic               res_ill;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign shamt    = inb[SHW-1:0];
  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (operation == OP_MUL) && (MUL_EN != 0);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (ina),
    .b       (inb),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle result and flags for whatever opcode is on the input
  always_comb begin
    res     = '0;
    res_cr  = 1'b0;
    res_ov  = 1'b0;
    res_ill = 1'b0;
    sum     = {1'b0, ina} + {1'b0, inb};
    diff    = {1'b0, ina} + {1'b0, ~inb} + (WIDTH+1)'(1);
    rot_l   = {ina, ina} << shamt;
    rot_r   = {ina, ina} >> shamt;
    case (operation)
      OP_AND:  res = ina & inb;
      OP_OR:   res = ina | inb;
      OP_ADD: begin
        res    = sum[WIDTH-1:0];
        res_cr = sum[WIDTH];
        res_ov = (ina[WIDTH-1] == inb[WIDTH-1]) && (sum[WIDTH-1] != ina[WIDTH-1]);
      end
      OP_SUB: begin
        res    = diff[WIDTH-1:0];
        res_cr = diff[WIDTH];
        res_ov = (ina[WIDTH-1] != inb[WIDTH-1]) && (diff[WIDTH-1] != ina[WIDTH-1]);
      end
      OP_LS:   res = ina << shamt;
      OP_SRS:  res = $signed(ina) >>> shamt;
      OP_URS:  res = ina >> shamt;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ina < inb};
      OP_SLTS: res = {{(WIDTH-1){1'b0}}, $signed(ina) < $signed(inb)};
      OP_RRO:  res = rot_r[WIDTH-1:0];
      OP_LRO:  res = rot_l[2*WIDTH-1:WIDTH];
      OP_MUL:  res_ill = (MUL_EN == 0);
      default: res_ill = 1'b1;
    endcase
  end

  // Controller and output register: accept in IDLE, wait out a MUL, hold results under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      cr        <= 1'b0;
      ov        <= 1'b0;
      ill       <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_MUL;
            end else begin
              out       <= res;
              cr        <= res_cr;
              ov        <= res_ov;
              ill       <= res_ill;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            out       <= mul_prod[WIDTH-1:0];
            cr        <= |mul_prod[2*WIDTH-1:WIDTH];
            ov        <= |mul_prod[2*WIDTH-1:WIDTH];
            ill       <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign zr = (out == '0);
  assign ng = out[WIDTH-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: an 8-bit instance under random and directed traffic
// checked against a queue-based behavioural model, plus 16/32-bit instances
// (the 32-bit one built without MUL) for add/sub and illegal-MUL regressions.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        il;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 1;
  logic [7:0] ina8 = 0, inb8 = 0, out8;
  logic [3:0] op8 = 0;
  logic       cr8, ov8, ng8, zr8, ill8;

  logic        in_valid_w = 0, out_ready_w = 1;
  logic        in_ready16, out_valid16, cr16, ov16, ng16, zr16, ill16;
  logic [15:0] ina16 = 0, inb16 = 0, out16;
  logic [3:0]  op16 = 0;
  logic        in_ready32, out_valid32, cr32, ov32, ng32, zr32, ill32;
  logic [31:0] ina32 = 0, inb32 = 0, out32;
  logic [3:0]  op32 = 0;

  int   total = 0;
  int   passed = 0;
  res_t expq[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .MUL_EN(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .ina(ina8), .inb(inb8), .operation(op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out(out8), .cr(cr8), .ov(ov8), .ng(ng8),
    .zr(zr8), .ill(ill8));

  alu_pipe #(.WIDTH(16), .MUL_EN(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready16),
    .ina(ina16), .inb(inb16), .operation(op16), .out_valid(out_valid16),
    .out_ready(out_ready_w), .out(out16), .cr(cr16), .ov(ov16), .ng(ng16),
    .zr(zr16), .ill(ill16));

  alu_pipe #(.WIDTH(32), .MUL_EN(0)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready32),
    .ina(ina32), .inb(inb32), .operation(op32), .out_valid(out_valid32),
    .out_ready(out_ready_w), .out(out32), .cr(cr32), .ov(ov32), .ng(ng32),
    .zr(zr32), .ill(ill32));

  // Two's-complement value of a w-bit field
  function automatic longint sx(input int w, input logic [63:0] x);
    if (x[w-1]) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  // What the ALU must produce for one operation, from plain integer arithmetic
  function automatic res_t model(input int w, input bit mul_en, input logic [3:0] op,
                                 input logic [63:0] a_raw, input logic [63:0] b_raw);
    res_t        e;
    logic [63:0] mask, a, b, p;
    int          sh;
    longint      sa, sb, d, hi, lo;
    mask = (64'd1 << w) - 64'd1;
    a    = a_raw & mask;
    b    = b_raw & mask;
    sh   = int'(b % w);
    sa   = sx(w, a);
    sb   = sx(w, b);
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -hi - 1;
    e.r = '0; e.c = 1'b0; e.v = 1'b0; e.il = 1'b0;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: begin
        p = a + b; e.r = p & mask; e.c = p[w];
        d = sa + sb; e.v = (d > hi) || (d < lo);
      end
      4'b0110: begin
        e.r = (a - b) & mask; e.c = (a >= b);
        d = sa - sb; e.v = (d > hi) || (d < lo);
      end
      4'b0011: e.r = (a << sh) & mask;
      4'b0100: begin p = sa >>> sh; e.r = p & mask; end
      4'b0101: e.r = a >> sh;
      4'b0111: e.r = (a < b) ? 64'd1 : 64'd0;
      4'b1000: e.r = ((a >> sh) | (a << (w - sh))) & mask;
      4'b1001: e.r = ((a << sh) | (a >> (w - sh))) & mask;
      4'b1010: begin
        if (mul_en) begin
          p = a * b; e.r = p & mask; e.c = ((p >> w) != 0); e.v = e.c;
        end else begin
          e.il = 1'b1;
        end
      end
      4'b1011: e.r = (sa < sb) ? 64'd1 : 64'd0;
      default: e.il = 1'b1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Present one op on the 8-bit instance for a cycle; record it in the model if accepted
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input bit rdy, output bit acc);
    @(negedge clk);
    in_valid8 = 1'b1; op8 = op; ina8 = a; inb8 = b; out_ready8 = rdy;
    #1;
    acc = in_ready8;
    if (acc) expq.push_back(model(8, 1'b1, op, {56'b0, a}, {56'b0, b}));
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  // Directed op with hand-computed expectations and latency
  task automatic runOne(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input bit ec, input bit ev,
                        input bit ezr, input bit eng, input bit eil, input int elat);
    bit acc;
    bit ir_seen;
    int n;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      applyStimulus(op, a, b, 1'b1, acc);
      tries++;
    end
    checkOutput({name, " accepted"}, acc, 1);
    n = 1;
    ir_seen = 1'b0;
    while (!out_valid8 && n < 40) begin
      if (in_ready8) ir_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, " out_valid"}, out_valid8, 1);
    checkOutput({name, " latency"}, n, elat);
    if (elat > 1) checkOutput({name, " in_ready low while busy"}, ir_seen, 0);
    checkOutput({name, " out"}, out8, er);
    checkOutput({name, " cr"}, cr8, ec);
    checkOutput({name, " ov"}, ov8, ev);
    checkOutput({name, " zr"}, zr8, ezr);
    checkOutput({name, " ng"}, ng8, eng);
    checkOutput({name, " ill"}, ill8, eil);
  endtask

  // Compare the 8-bit output register against the model on every valid cycle
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && out_valid8 === 1'b1) begin
        if (expq.size() == 0) begin
          checkOutput("spurious result", out_valid8, 0);
        end else begin
          e = expq[0];
          checkOutput("model out", out8, e.r[7:0]);
          checkOutput("model cr", cr8, e.c);
          checkOutput("model ov", ov8, e.v);
          checkOutput("model ill", ill8, e.il);
          checkOutput("model zr", zr8, (e.r[7:0] == 8'h00));
          checkOutput("model ng", ng8, e.r[7]);
          if (out_ready8) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          acc;
    int          n;
    int          vcount;
    logic [31:0] a, b;
    res_t        e16, e32;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", out_valid8, 0);
    checkOutput("reset out", out8, 0);
    checkOutput("reset zr", zr8, 1);
    checkOutput("reset ng", ng8, 0);
    checkOutput("reset cr", cr8, 0);
    checkOutput("reset ov", ov8, 0);
    checkOutput("reset ill", ill8, 0);
    #1 rst = 1'b0;
    #1 checkOutput("reset in_ready", in_ready8, 1);

    // Directed literal cases
    runOne("ADD 7F+01", OP_ADD, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 0, 1);
    runOne("SUB 00-01", OP_SUB, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 1, 0, 1);
    runOne("SUB 05-05", OP_SUB, 8'h05, 8'h05, 8'h00, 1, 0, 1, 0, 0, 1);
    runOne("SRS 90>>3", OP_SRS, 8'h90, 8'h03, 8'hF2, 0, 0, 0, 1, 0, 1);
    runOne("URS 90>>3", OP_URS, 8'h90, 8'h03, 8'h12, 0, 0, 0, 0, 0, 1);
    runOne("LS 81<<1", OP_LS, 8'h81, 8'h01, 8'h02, 0, 0, 0, 0, 0, 1);
    runOne("LRO 81,1", OP_LRO, 8'h81, 8'h01, 8'h03, 0, 0, 0, 0, 0, 1);
    runOne("RRO 81,9", OP_RRO, 8'h81, 8'h09, 8'hC0, 0, 0, 0, 1, 0, 1);
    runOne("SLT FF,01", OP_SLT, 8'hFF, 8'h01, 8'h00, 0, 0, 1, 0, 0, 1);
    runOne("SLTS FF,01", OP_SLTS, 8'hFF, 8'h01, 8'h01, 0, 0, 0, 0, 0, 1);
    runOne("MUL 10*10", OP_MUL, 8'h10, 8'h10, 8'h00, 1, 1, 1, 0, 0, 9);
    runOne("MUL 0F*0F", OP_MUL, 8'h0F, 8'h0F, 8'hE1, 0, 0, 0, 1, 0, 9);
    runOne("ILLEGAL 1110", 4'b1110, 8'h5A, 8'hA5, 8'h00, 0, 0, 1, 0, 1, 1);

    // Backpressure: first result held, next op waits, then transfer+accept on one edge
    @(negedge clk);
    out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(OP_ADD, 8'h12, 8'h34, 1'b0, acc);
    checkOutput("bp first accepted", acc, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(OP_ADD, 8'hF0, 8'h20, 1'b0, acc);
      checkOutput("bp stalled in_ready", acc, 0);
      checkOutput("bp held out", out8, 8'h46);
      checkOutput("bp held out_valid", out_valid8, 1);
    end
    applyStimulus(OP_ADD, 8'hF0, 8'h20, 1'b1, acc);
    checkOutput("bp release accepted", acc, 1);
    checkOutput("bp second out", out8, 8'h10);
    checkOutput("bp second cr", cr8, 1);
    checkOutput("bp second out_valid", out_valid8, 1);

    // Asynchronous reset during MUL iteration 4
    applyStimulus(OP_MUL, 8'h03, 8'h05, 1'b1, acc);
    checkOutput("rst-mul accepted", acc, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst-mul out_valid", out_valid8, 0);
    checkOutput("rst-mul zr", zr8, 1);
    #1 rst = 1'b0;
    expq.delete();
    #1 checkOutput("rst-mul in_ready after release", in_ready8, 1);
    vcount = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid8) vcount++;
    end
    checkOutput("rst-mul no stale result", vcount, 0);
    runOne("ADD after rst", OP_ADD, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 0, 1);

    // Random traffic on the 8-bit instance with random backpressure
    for (int i = 0; i < 250; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 8'($urandom()), 8'($urandom()),
                    ($urandom_range(0, 3) != 0), acc);
    end
    @(negedge clk);
    out_ready8 = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain no lost ops", expq.size(), 0);
    @(posedge clk);
    #1 checkOutput("drain out_valid low", out_valid8, 0);

    // 16/32-bit regressions; the 32-bit build has no multiplier
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = $urandom();
      b = $urandom();
      op16 = ($urandom_range(0, 1) != 0) ? OP_ADD : OP_SUB;
      op32 = (i % 5 == 1) ? OP_MUL : (($urandom_range(0, 1) != 0) ? OP_ADD : OP_SUB);
      if (i == 0) begin
        a = 32'h7FFF_FFFF; b = 32'h0000_0001; op16 = OP_ADD; op32 = OP_ADD;
      end else if (i == 1) begin
        a = 32'h0000_0010; b = 32'h0000_0010;
      end
      ina16 = a[15:0]; inb16 = b[15:0]; ina32 = a; inb32 = b;
      in_valid_w = 1'b1;
      #1;
      checkOutput("w16 in_ready", in_ready16, 1);
      checkOutput("w32 in_ready", in_ready32, 1);
      e16 = model(16, 1'b1, op16, {32'b0, a}, {32'b0, b});
      e32 = model(32, 1'b0, op32, {32'b0, a}, {32'b0, b});
      @(posedge clk);
      #1;
      in_valid_w = 1'b0;
      checkOutput("w16 out_valid", out_valid16, 1);
      checkOutput("w16 out", out16, e16.r[15:0]);
      checkOutput("w16 cr", cr16, e16.c);
      checkOutput("w16 ov", ov16, e16.v);
      checkOutput("w16 zr", zr16, (e16.r[15:0] == 16'h0));
      checkOutput("w16 ng", ng16, e16.r[15]);
      checkOutput("w32 out_valid", out_valid32, 1);
      checkOutput("w32 out", out32, e32.r[31:0]);
      checkOutput("w32 cr", cr32, e32.c);
      checkOutput("w32 ov", ov32, e32.v);
      checkOutput("w32 ill", ill32, e32.il);
      checkOutput("w32 zr", zr32, (e32.r[31:0] == 32'h0));
      checkOutput("w32 ng", ng32, e32.r[31]);
      if (i == 0) begin
        checkOutput("w32 ADD 7FFFFFFF+1 out", out32, 32'h8000_0000);
        checkOutput("w32 ADD 7FFFFFFF+1 ov", ov32, 1);
        checkOutput("w16 ADD FFFF+1 cr", cr16, 1);
      end else if (i == 1) begin
        checkOutput("w32 MUL disabled ill", ill32, 1);
        checkOutput("w32 MUL disabled out", out32, 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
